// File: rtl/lv_efuse_load_ctrl_pkg.sv
// Types shared by the efuse load controller.
// efuse_st_e : loader FSM state encoding.
`include "lv_param.svh"

package lv_efuse_load_ctrl_pkg;

  typedef enum logic [`EFUSE_FSM_ST_W-1:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    WRITE  = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5
  } efuse_st_e;

endpackage

// File: rtl/lv_param.svh
// Shared LV-domain parameter defaults.
// EFUSE_* : efuse loader geometry and macro access timing.
// EFUSE_FSM_ST_W : encoding width of the efuse loader state register.
`ifndef LV_PARAM_SVH
`define LV_PARAM_SVH

`define EFUSE_WORD_NUM     8
`define EFUSE_DATA_W       8
`define EFUSE_ADDR_W       3
`define EFUSE_SETUP_CYC    2
`define EFUSE_RD_PULSE_CYC 4
`define EFUSE_FSM_ST_W     3

`endif

// File: rtl/lv_efuse_load_ctrl.sv
// Efuse load controller: on a permitted load request, reads every efuse word
// through the macro (csb setup, then read strobe), writes all data words to
// the register file and checks the XOR of the data words against the last
// (checksum) word.
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_efuse_load_req        level load request
//   i_efuse_ctrl_reg_en     load permission, low aborts
//   o_efuse_load_done       one-cycle completion pulse
//   o_efuse_csb/strobe/addr efuse macro access, i_efuse_dout read data
//   o_efuse_reg_wr_en/addr/wdata  register-file write port
//   o_efuse_vld/chk_err     checksum result levels
`include "lv_param.svh"

module lv_efuse_load_ctrl
  import lv_efuse_load_ctrl_pkg::*;
#(
  parameter int EFUSE_WORD_NUM     = `EFUSE_WORD_NUM,
  parameter int EFUSE_DATA_W       = `EFUSE_DATA_W,
  parameter int EFUSE_ADDR_W       = `EFUSE_ADDR_W,
  parameter int EFUSE_SETUP_CYC    = `EFUSE_SETUP_CYC,
  parameter int EFUSE_RD_PULSE_CYC = `EFUSE_RD_PULSE_CYC
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_efuse_load_req,
  input  logic                    i_efuse_ctrl_reg_en,
  output logic                    o_efuse_load_done,
  output logic                    o_efuse_csb,
  output logic                    o_efuse_strobe,
  output logic [EFUSE_ADDR_W-1:0] o_efuse_addr,
  input  logic [EFUSE_DATA_W-1:0] i_efuse_dout,
  output logic                    o_efuse_reg_wr_en,
  output logic [EFUSE_ADDR_W-1:0] o_efuse_reg_addr,
  output logic [EFUSE_DATA_W-1:0] o_efuse_reg_wdata,
  output logic                    o_efuse_vld,
  output logic                    o_efuse_chk_err
);

  localparam int PH_MAX = (EFUSE_SETUP_CYC > EFUSE_RD_PULSE_CYC) ?
                          EFUSE_SETUP_CYC : EFUSE_RD_PULSE_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [EFUSE_ADDR_W-1:0] LAST_ADDR = EFUSE_ADDR_W'(EFUSE_WORD_NUM - 1);

  efuse_st_e               st, st_nxt;
  logic [EFUSE_ADDR_W-1:0] addr;
  logic [EFUSE_DATA_W-1:0] cap;   // last word read from the macro
  logic [EFUSE_DATA_W-1:0] acc;   // running XOR of data words
  logic [PH_W-1:0]         ph_cnt;
  logic                    vld, chk_err;

  logic at_last, setup_end, strobe_end, start, abort;

  assign at_last    = (addr == LAST_ADDR);
  assign setup_end  = (ph_cnt == PH_W'(EFUSE_SETUP_CYC - 1));
  assign strobe_end = (ph_cnt == PH_W'(EFUSE_RD_PULSE_CYC - 1));
  assign start      = (st == IDLE) && i_efuse_load_req && i_efuse_ctrl_reg_en;
  assign abort      = (st != IDLE) && !i_efuse_ctrl_reg_en;

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (start) st_nxt = SETUP;
      SETUP:   if (setup_end) st_nxt = STROBE;
      STROBE:  if (strobe_end) st_nxt = WRITE;
      WRITE:   st_nxt = at_last ? CHECK : SETUP;
      CHECK:   st_nxt = DONE;
      DONE:    st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
    // Permission loss wins over every in-flight transition.
    if (abort) st_nxt = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st      <= IDLE;
      addr    <= '0;
      cap     <= '0;
      acc     <= '0;
      ph_cnt  <= '0;
      vld     <= 1'b0;
      chk_err <= 1'b0;
    end else begin
      st <= st_nxt;
      if (start) begin
        addr    <= '0;
        acc     <= '0;
        ph_cnt  <= '0;
        vld     <= 1'b0;
        chk_err <= 1'b0;
      end else if (abort) begin
        // Freeze datapath; vld/chk_err remain as cleared at load start.
        ph_cnt <= '0;
      end else begin
        case (st)
          SETUP:  ph_cnt <= setup_end ? '0 : ph_cnt + PH_W'(1);
          STROBE: begin
            if (strobe_end) begin
              cap    <= i_efuse_dout;
              ph_cnt <= '0;
            end else begin
              ph_cnt <= ph_cnt + PH_W'(1);
            end
          end
          WRITE: begin
            // The checksum word is neither written nor accumulated, and the
            // address stops at the last word.
            if (!at_last) begin
              acc  <= acc ^ cap;
              addr <= addr + EFUSE_ADDR_W'(1);
            end
          end
          CHECK: begin
            vld     <= (acc == cap);
            chk_err <= (acc != cap);
          end
          default: ;
        endcase
      end
    end
  end

  assign o_efuse_csb       = !((st == SETUP) || (st == STROBE) || (st == WRITE));
  assign o_efuse_strobe    = (st == STROBE);
  assign o_efuse_addr      = addr;
  assign o_efuse_reg_wr_en = (st == WRITE) && !at_last;
  assign o_efuse_reg_addr  = addr;
  assign o_efuse_reg_wdata = cap;
  assign o_efuse_load_done = (st == DONE);
  assign o_efuse_vld       = vld;
  assign o_efuse_chk_err   = chk_err;

endmodule

// File: tb/tb_lv_efuse_load_ctrl.sv
// Bench for lv_efuse_load_ctrl: directed loads with an efuse macro model;
// expected writes/done pulses are queued at load start and popped by a
// negedge monitor that also checks csb/strobe timing per word.
module tb_lv_efuse_load_ctrl;

  localparam int N   = 8;
  localparam int DW  = 8;
  localparam int AW  = 3;
  localparam int LAT = 58;
  localparam int WCY = 7;  // setup + strobe + write cycles per word
  localparam logic [DW-1:0] DATA [7] = '{8'h11, 8'h22, 8'h44, 8'h88, 8'h01, 8'h02, 8'h04};

  logic          clk = 1'b0, rst_n = 1'b0, req = 1'b0, en = 1'b0;
  logic          done, csb, strobe, wr_en, vld, err;
  logic [AW-1:0] addr, reg_addr;
  logic [DW-1:0] dout, wdata;
  logic [DW-1:0] mem [N];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign dout = mem[addr];

  lv_efuse_load_ctrl dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_efuse_load_req    (req),
    .i_efuse_ctrl_reg_en (en),
    .o_efuse_load_done   (done),
    .o_efuse_csb         (csb),
    .o_efuse_strobe      (strobe),
    .o_efuse_addr        (addr),
    .i_efuse_dout        (dout),
    .o_efuse_reg_wr_en   (wr_en),
    .o_efuse_reg_addr    (reg_addr),
    .o_efuse_reg_wdata   (wdata),
    .o_efuse_vld         (vld),
    .o_efuse_chk_err     (err)
  );

  typedef struct {
    bit            is_done;
    int            cyc;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            v;
    bit            e;
  } exp_t;

  exp_t q[$];
  exp_t ev;
  int   n_chk = 0, n_pass = 0;
  int   t0, pre = 0, stb = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  // Queue nwr writes (words 0..nwr-1) and optionally the done pulse of a load
  // whose request is sampled in IDLE at cycle ts.
  task automatic push_load(input int ts, input int nwr, input bit with_done, input bit v);
    exp_t x;
    for (int i = 0; i < nwr; i++) begin
      x.is_done = 1'b0; x.cyc = ts + WCY * (i + 1);
      x.a = AW'(i); x.d = DATA[i]; x.v = 1'b0; x.e = 1'b0;
      q.push_back(x);
    end
    if (with_done) begin
      x.is_done = 1'b1; x.cyc = ts + LAT; x.a = '0; x.d = '0; x.v = v; x.e = !v;
      q.push_back(x);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < bound);
    if (!done) begin
      n_chk++;
      $display("FAIL done_timeout: no done within %0d cycles", bound);
    end
  endtask

  // Scoreboard monitor plus per-word csb/strobe timing check.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en || done) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_event: wr_en=%0b done=%0b addr=%0d data=0x%0h, expected none (cycle %0d)",
                   wr_en, done, reg_addr, wdata, cyc);
        end else begin
          ev = q.pop_front();
          if (ev.is_done)
            chk("done_event", 32'({done, wr_en, vld, err}), 32'({1'b1, 1'b0, ev.v, ev.e}));
          else
            chk("write_event", 32'({wr_en, done, reg_addr, wdata}), 32'({1'b1, 1'b0, ev.a, ev.d}));
          chk("event_cycle", 32'(cyc), 32'(ev.cyc));
        end
      end
      if (csb) begin
        pre = 0; stb = 0;
      end else if (strobe) begin
        if (stb == 0) chk("setup_cycles", 32'(pre), 32'd2);
        stb++;
      end else if (stb != 0) begin
        // first csb-low, strobe-low cycle after the pulse is the write slot
        chk("strobe_cycles", 32'(stb), 32'd4);
        stb = 0; pre = 0;
      end else begin
        pre++;
      end
    end else begin
      pre = 0; stb = 0;
    end
  end

  initial begin
    for (int i = 0; i < 7; i++) mem[i] = DATA[i];
    mem[7] = 8'hF8;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_csb", 32'(csb), 32'd1);
    chk("rst_strobe", 32'(strobe), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_reg_addr", 32'(reg_addr), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    chk("rst_vld_err", 32'({vld, err}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // request without permission stays idle
    req = 1'b1; en = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_en_csb", 32'(csb), 32'd1);
    chk("no_en_vld_err", 32'({vld, err}), 32'd0);

    // good load, request held high -> back-to-back load with bad checksum
    t0 = cyc; en = 1'b1;
    push_load(t0, 7, 1'b1, 1'b1);
    push_load(t0 + LAT + 1, 7, 1'b1, 1'b0);
    wait_until(t0 + LAT);
    mem[7] = 8'hF9;
    @(negedge clk);
    chk("vld_hold_idle", 32'({vld, err}), 32'd2);
    @(negedge clk);
    chk("restart_csb", 32'(csb), 32'd0);
    chk("restart_vld_clr", 32'({vld, err}), 32'd0);
    wait_done(200);
    req = 1'b0;
    @(negedge clk);
    chk("err_hold", 32'({vld, err}), 32'd1);
    repeat (3) @(negedge clk);
    chk("no_third_load", 32'(csb), 32'd1);

    // abort during strobe of word 3
    mem[7] = 8'hF8;
    @(negedge clk);
    t0 = cyc; req = 1'b1; en = 1'b1;
    push_load(t0, 3, 1'b0, 1'b0);
    wait_until(t0 + 25);
    chk("abort_in_strobe", 32'({strobe, addr}), 32'({1'b1, 3'd3}));
    en = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("abort_csb_strobe", 32'({csb, strobe}), 32'd2);
    repeat (80) @(negedge clk);
    chk("abort_sb_empty", 32'(q.size()), 32'd0);
    chk("abort_vld_err", 32'({vld, err}), 32'd0);

    // reset during write of word 5, then restart
    @(negedge clk);
    t0 = cyc; req = 1'b1; en = 1'b1;
    push_load(t0, 6, 1'b0, 1'b0);
    wait_until(t0 + 42);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_csb_strobe", 32'({csb, strobe}), 32'd2);
    chk("mid_rst_wr_done", 32'({wr_en, done}), 32'd0);
    chk("mid_rst_addrs", 32'({addr, reg_addr, wdata}), 32'd0);
    chk("mid_rst_vld_err", 32'({vld, err}), 32'd0);
    req = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sb_empty", 32'(q.size()), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    t0 = cyc; req = 1'b1;
    push_load(t0, 7, 1'b1, 1'b1);
    wait_done(100);
    req = 1'b0;
    repeat (4) @(negedge clk);
    chk("final_sb_empty", 32'(q.size()), 32'd0);
    chk("final_vld_err", 32'({vld, err}), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lv_efuse_load_ctrl.md
LV_EFUSE_LOAD_CTRL -- requirements
Module: lv_efuse_load_ctrl

Interface
REQ-001 Parameters SHALL be supplied through `include "lv_param.svh" and SHALL be:
- EFUSE_WORD_NUM, default 8: number of efuse words; the last word is the checksum.
- EFUSE_DATA_W, default 8: word width.
- EFUSE_ADDR_W, default 3: word address width.
- EFUSE_SETUP_CYC, default 2: csb-to-strobe setup cycles.
- EFUSE_RD_PULSE_CYC, default 4: strobe high cycles.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- i_clk  in  1  single clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_efuse_load_req  in  1  level load request from the LV control FSM.
- i_efuse_ctrl_reg_en  in  1  load permission; low aborts.
- o_efuse_load_done  out  1  one-cycle completion pulse.
- o_efuse_csb  out  1  efuse macro chip select, active low.
- o_efuse_strobe  out  1  efuse read strobe.
- o_efuse_addr  out  EFUSE_ADDR_W  macro word address.
- i_efuse_dout  in  EFUSE_DATA_W  macro read data.
- o_efuse_reg_wr_en  out  1  register-file write pulse.
- o_efuse_reg_addr  out  EFUSE_ADDR_W  register word index.
- o_efuse_reg_wdata  out  EFUSE_DATA_W  register write data.
- o_efuse_vld  out  1  checksum passed (level).
- o_efuse_chk_err  out  1  checksum failed (level).

Function
REQ-003 The FSM SHALL have the states IDLE, SETUP, STROBE, WRITE, CHECK and DONE; all outputs SHALL be decoded from registered state and registers, with no combinational path from inputs to outputs.
REQ-004 In IDLE, if i_efuse_load_req and i_efuse_ctrl_reg_en are both 1, the block SHALL go to SETUP next cycle, clear the address, XOR accumulator, o_efuse_vld and o_efuse_chk_err.
REQ-005 o_efuse_csb SHALL be 0 in SETUP, STROBE and WRITE, and 1 otherwise.
REQ-006 SETUP SHALL last exactly EFUSE_SETUP_CYC cycles, then go to STROBE.
REQ-007 STROBE SHALL drive o_efuse_strobe=1 for exactly EFUSE_RD_PULSE_CYC cycles.
REQ-008 i_efuse_dout SHALL be captured on the last STROBE cycle, then the FSM SHALL go to WRITE.
REQ-009 WRITE SHALL last one cycle.
- For address < EFUSE_WORD_NUM-1: assert o_efuse_reg_wr_en=1, drive o_efuse_reg_addr equal to the current address and o_efuse_reg_wdata equal to the captured word, XOR the word into the accumulator, increment the address and return to SETUP.
- For address = EFUSE_WORD_NUM-1: no write; go to CHECK.
REQ-010 CHECK SHALL last one cycle and compare the accumulator with the captured checksum word.
- Equal: o_efuse_vld=1, o_efuse_chk_err=0.
- Not equal: o_efuse_vld=0, o_efuse_chk_err=1.
- Values are visible from the DONE cycle onward and hold until the next load start.
REQ-011 DONE SHALL assert o_efuse_load_done=1 for exactly one cycle, then return to IDLE.
REQ-012 Latency: with the request sampled in IDLE at cycle 0, the done pulse SHALL occur at cycle EFUSE_WORD_NUM*(EFUSE_SETUP_CYC+EFUSE_RD_PULSE_CYC+1)+2, which is 58 with default parameters.
REQ-013 A request still high in the cycle after DONE SHALL start a new load; the requester clears its request on sampling done.
REQ-014 Changes of i_efuse_load_req while not in IDLE SHALL be ignored.
REQ-015 If i_efuse_ctrl_reg_en=0 in any non-IDLE state, the FSM SHALL go to IDLE next cycle:
- csb=1 and strobe=0 from that cycle on;
- no done pulse and no further writes;
- o_efuse_vld and o_efuse_chk_err stay cleared.
REQ-016 If the request and i_efuse_ctrl_reg_en=0 coincide in IDLE, the FSM SHALL remain in IDLE.
REQ-017 The address SHALL never exceed EFUSE_WORD_NUM-1; an illegal state encoding SHALL go to IDLE.

Reset
REQ-018 On i_rst_n=0 the block SHALL asynchronously enter IDLE with the following reset values:
- o_efuse_csb=1; all other outputs 0;
- o_efuse_addr, o_efuse_reg_addr, o_efuse_reg_wdata = 0;
- accumulator, capture register and phase counter = 0.
REQ-019 Reset asserted mid-load SHALL abort the macro access immediately, with csb=1 and strobe=0 while reset is active.

Structure
REQ-020 The EFUSE_* parameters and the EFUSE_FSM_ST_W state-width constant SHALL reside in the shared lv_param.svh.
REQ-021 The single phase counter SHALL be implemented inline; no sub-module SHALL be used.

Verification
REQ-022 Default load: words 0x11,0x22,0x44,0x88,0x01,0x02,0x04 with checksum 0xF8 -> seven writes to addresses 0..6 with matching data, done at cycle 58, o_efuse_vld=1, o_efuse_chk_err=0.
REQ-023 Bad checksum 0xF9 with the same data words -> done at cycle 58, o_efuse_vld=0, o_efuse_chk_err=1.
REQ-024 Request held high after done -> a second load starts on the cycle after DONE, and o_efuse_vld clears at its start.
REQ-025 Abort: i_efuse_ctrl_reg_en dropped during the STROBE of word 3 -> next cycle IDLE, csb=1, no done, only writes 0..2 issued.
REQ-026 Reset asserted during WRITE of word 5 -> all outputs reach reset values asynchronously, and a restart after reset reloads from address 0.
REQ-027 Timing check: for every word, exactly 2 cycles of csb=0 with strobe=0 precede exactly 4 cycles of strobe=1.
